// File: rtl/mnist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mnist_pkg
// Description : Shared sizes, score type and FSM state encoding for the
//               MNIST argmax classification back-end.
// Revision    : 1.0 - initial release
// ============================================================================
package mnist_pkg;

    localparam int N         = 8;   // bit width of one class score
    localparam int NUM_CLASS = 10;  // number of class scores per vector
    localparam int IDX_W     = 4;   // class index width (2**IDX_W >= NUM_CLASS)

    typedef logic signed [N-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mnist_pkg
`default_nettype wire

// File: rtl/mnist_argmax_if.sv
`default_nettype none
// ============================================================================
// Module      : mnist_argmax_if
// Description : Score-vector input and classification result bundle for
//               mnist_argmax. The class_margin member exists only when
//               MNIST_ARGMAX_MARGIN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mnist_argmax_if;
    import mnist_pkg::*;

    logic                   ce;
    logic                   din_vld;
    logic [NUM_CLASS*N-1:0] din;
    logic                   din_end;
    logic                   busy;
    logic                   class_vld;
    logic [IDX_W-1:0]       class_idx;
    score_t                 class_score;
    logic                   class_last;
    logic                   overrun;
`ifdef MNIST_ARGMAX_MARGIN_EN
    logic [N:0]             class_margin;
`endif

    // Upstream side: supplies vectors and clock enable, observes results
    modport master (
        output ce, din_vld, din, din_end,
        input  busy, class_vld, class_idx, class_score, class_last, overrun
`ifdef MNIST_ARGMAX_MARGIN_EN
        , input class_margin
`endif
    );

    // Argmax side
    modport slave (
        input  ce, din_vld, din, din_end,
        output busy, class_vld, class_idx, class_score, class_last, overrun
`ifdef MNIST_ARGMAX_MARGIN_EN
        , output class_margin
`endif
    );

endinterface : mnist_argmax_if
`default_nettype wire

// File: rtl/mnist_argmax_cmp.sv
`default_nettype none
// ============================================================================
// Module      : mnist_argmax_cmp
// Description : Combinational signed compare-and-select of two (score, idx)
//               pairs. The challenger b wins only when strictly greater, so
//               ties keep the incumbent a.
// Revision    : 1.0 - initial release
// ============================================================================
module mnist_argmax_cmp
    import mnist_pkg::*;
(
    input  score_t           a_score,
    input  logic [IDX_W-1:0] a_idx,
    input  score_t           b_score,
    input  logic [IDX_W-1:0] b_idx,
    output score_t           sel_score,
    output logic [IDX_W-1:0] sel_idx
);
    logic w_b_wins;

    // Both operands are signed, so this is a two's complement compare
    assign w_b_wins  = (b_score > a_score);
    assign sel_score = w_b_wins ? b_score : a_score;
    assign sel_idx   = w_b_wins ? b_idx   : a_idx;

endmodule : mnist_argmax_cmp
`default_nettype wire

// File: rtl/mnist_argmax.sv
`default_nettype none
// ============================================================================
// Module      : mnist_argmax
// Description : Serial argmax over a NUM_CLASS-entry signed score vector.
//               One class is compared per enabled cycle; the winning index,
//               score and end tag are presented with a one-cycle class_vld.
//               Optional feature macro: MNIST_ARGMAX_MARGIN_EN adds
//               class_margin = best score - runner-up score.
// Revision    : 1.0 - initial release
// ============================================================================
module mnist_argmax
    import mnist_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mnist_argmax_if.slave bus
);
    state_t                 r_state;
    state_t                 w_next;
    score_t [NUM_CLASS-1:0] r_vec;
    logic                   r_end;
    logic [IDX_W-1:0]       r_cnt;
    score_t                 r_best_score;
    logic [IDX_W-1:0]       r_best_idx;
    logic [IDX_W-1:0]       r_class_idx;
    score_t                 r_class_score;
    logic                   r_class_last;
    logic                   r_overrun;

    score_t                 w_cand;
    score_t                 w_sel_score;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_last;

    assign w_cand = r_vec[r_cnt];
    assign w_last = (r_cnt == IDX_W'(NUM_CLASS - 1));

    mnist_argmax_cmp u_cmp_best (
        .a_score   (r_best_score),
        .a_idx     (r_best_idx),
        .b_score   (w_cand),
        .b_idx     (r_cnt),
        .sel_score (w_sel_score),
        .sel_idx   (w_sel_idx)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (bus.ce) begin
            r_state <= w_next;
        end
    end

    // FSM next state; a single-class vector needs no scan at all
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.din_vld) w_next = (NUM_CLASS == 1) ? DONE : SCAN;
            SCAN:    if (w_last)      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Vector capture, running maximum, published result and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec         <= '0;
            r_end         <= 1'b0;
            r_cnt         <= '0;
            r_best_score  <= '0;
            r_best_idx    <= '0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_class_last  <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (bus.ce) begin
            // Vectors arriving outside IDLE are dropped and flagged
            if ((r_state != IDLE) && bus.din_vld) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.din_vld) begin
                        r_vec        <= bus.din;
                        r_end        <= bus.din_end;
                        r_best_score <= score_t'(bus.din[N-1:0]);
                        r_best_idx   <= '0;
                        r_cnt        <= IDX_W'(1);
                        if (NUM_CLASS == 1) begin
                            r_class_idx   <= '0;
                            r_class_score <= score_t'(bus.din[N-1:0]);
                            r_class_last  <= bus.din_end;
                        end
                    end
                end
                SCAN: begin
                    r_best_score <= w_sel_score;
                    r_best_idx   <= w_sel_idx;
                    r_cnt        <= r_cnt + IDX_W'(1);
                    if (w_last) begin
                        r_class_idx   <= w_sel_idx;
                        r_class_score <= w_sel_score;
                        r_class_last  <= r_end;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MNIST_ARGMAX_MARGIN_EN
    score_t           r_second;
    logic [N:0]       r_class_margin;
    score_t           w_sec_score;
    logic [IDX_W-1:0] w_sec_idx;
    score_t           w_new_second;
    logic [N:0]       w_margin;

    // Runner-up candidate: ties with the runner-up do not matter, but a
    // candidate equal to the best still beats any lower runner-up
    mnist_argmax_cmp u_cmp_second (
        .a_score   (r_second),
        .a_idx     (r_best_idx),
        .b_score   (w_cand),
        .b_idx     (r_cnt),
        .sel_score (w_sec_score),
        .sel_idx   (w_sec_idx)
    );

    // A new best demotes the old best to runner-up
    assign w_new_second = (w_sel_idx == r_cnt) ? r_best_score : w_sec_score;
    assign w_margin     = {w_sel_score[N-1], w_sel_score}
                        - {w_new_second[N-1], w_new_second};

    // Runner-up tracking and margin publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_second       <= '0;
            r_class_margin <= '0;
        end else if (bus.ce) begin
            case (r_state)
                IDLE: begin
                    if (bus.din_vld) begin
                        r_second <= {1'b1, {(N-1){1'b0}}};
                        if (NUM_CLASS == 1) begin
                            r_class_margin <= '0;
                        end
                    end
                end
                SCAN: begin
                    r_second <= w_new_second;
                    if (w_last) begin
                        r_class_margin <= w_margin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.class_margin = r_class_margin;
`endif

    assign bus.busy        = (r_state == SCAN);
    assign bus.class_vld   = (r_state == DONE);
    assign bus.class_idx   = r_class_idx;
    assign bus.class_score = r_class_score;
    assign bus.class_last  = r_class_last;
    assign bus.overrun     = r_overrun;

endmodule : mnist_argmax
`default_nettype wire
